mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single external memory port between the instruction-cache line refill and the MEM-stage data access of the 5-stage RISC-V core. It serialises accesses, runs multi-beat refill bursts, and alternates round-robin under contention. It also generates the stall requests that the pipeline stall controller consumes: `stallreq_ic` for instruction fetch and `stallreq_dm` for data access.

---
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares the single memory port between I-cache line refills and MEM-stage data
// accesses: round-robin grant, multi-beat refill bursts, pipeline stall requests.
module mem_arbiter #(
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ic_req,
   input  logic [31:0]                   ic_addr,
   output logic [31:0]                   ic_rdata,
   output logic                          ic_rvalid,
   output logic [$clog2(LINE_WORDS)-1:0] ic_beat,
   output logic                          ic_done,
   input  logic                          dm_req,
   input  logic                          dm_we,
   input  logic [31:0]                   dm_addr,
   input  logic [31:0]                   dm_wdata,
   input  logic [3:0]                    dm_sel,
   output logic [31:0]                   dm_rdata,
   output logic                          dm_done,
   output logic                          mem_ce,
   output logic                          mem_we,
   output logic [31:0]                   mem_addr,
   output logic [31:0]                   mem_wdata,
   output logic [3:0]                    mem_sel,
   input  logic [31:0]                   mem_rdata,
   input  logic                          mem_ack,
   output logic                          stallreq_ic,
   output logic                          stallreq_dm
);
   localparam int unsigned BW = $clog2(LINE_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_IC_BURST, S_DM_ACC} state_t;
   typedef enum logic {REQ_IC, REQ_DM} req_t;

   state_t           state_q, state_d;
   req_t             last_q, last_d;
   logic [BW-1:0]    beat_q, beat_d, beat_inc;
   logic [31:2+BW]   line_q, line_d;
   logic             mem_ce_q, mem_ce_d, mem_we_q, mem_we_d;
   logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]       mem_sel_q, mem_sel_d;
   logic [31:0]      ic_rdata_q, ic_rdata_d, dm_rdata_q, dm_rdata_d;
   logic             ic_rvalid_q, ic_rvalid_d, ic_done_q, ic_done_d;
   logic [BW-1:0]    ic_beat_q, ic_beat_d;
   logic             dm_done_q, dm_done_d;
   logic             ic_elig, dm_elig;
   logic             unused_line_offset;

   // Word offset within the line is regenerated from the beat counter.
   assign unused_line_offset = ^ic_addr[1+BW:0];

   assign ic_elig  = ic_req & ~ic_done_q;
   assign dm_elig  = dm_req & ~dm_done_q;
   assign beat_inc = beat_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      beat_d      = beat_q;
      line_d      = line_q;
      mem_ce_d    = mem_ce_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_sel_d   = mem_sel_q;
      ic_rdata_d  = ic_rdata_q;
      ic_beat_d   = ic_beat_q;
      dm_rdata_d  = dm_rdata_q;
      ic_rvalid_d = 1'b0;
      ic_done_d   = 1'b0;
      dm_done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ic_elig && (!dm_elig || last_q == REQ_DM)) begin
               state_d    = S_IC_BURST;
               last_d     = REQ_IC;
               beat_d     = '0;
               line_d     = ic_addr[31:2+BW];
               mem_ce_d   = 1'b1;
               mem_we_d   = 1'b0;
               mem_sel_d  = 4'hF;
               mem_addr_d = {ic_addr[31:2+BW], {BW{1'b0}}, 2'b00};
            end else if (dm_elig) begin
               state_d     = S_DM_ACC;
               last_d      = REQ_DM;
               mem_ce_d    = 1'b1;
               mem_we_d    = dm_we;
               mem_sel_d   = dm_sel;
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
            end
         end
         S_IC_BURST: begin
            if (mem_ack) begin
               ic_rdata_d  = mem_rdata;
               ic_rvalid_d = 1'b1;
               ic_beat_d   = beat_q;
               beat_d      = beat_inc;
               if (&beat_q) begin
                  ic_done_d = 1'b1;
                  mem_ce_d  = 1'b0;
                  state_d   = S_IDLE;
               end else begin
                  mem_addr_d = {line_q, beat_inc, 2'b00};
               end
            end
         end
         S_DM_ACC: begin
            if (mem_ack) begin
               dm_rdata_d = mem_rdata;
               dm_done_d  = 1'b1;
               mem_ce_d   = 1'b0;
               mem_we_d   = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_q      <= REQ_DM;
         beat_q      <= '0;
         line_q      <= '0;
         mem_ce_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_sel_q   <= '0;
         ic_rdata_q  <= '0;
         ic_rvalid_q <= 1'b0;
         ic_beat_q   <= '0;
         ic_done_q   <= 1'b0;
         dm_rdata_q  <= '0;
         dm_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         beat_q      <= beat_d;
         line_q      <= line_d;
         mem_ce_q    <= mem_ce_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_sel_q   <= mem_sel_d;
         ic_rdata_q  <= ic_rdata_d;
         ic_rvalid_q <= ic_rvalid_d;
         ic_beat_q   <= ic_beat_d;
         ic_done_q   <= ic_done_d;
         dm_rdata_q  <= dm_rdata_d;
         dm_done_q   <= dm_done_d;
      end
   end

   assign mem_ce      = mem_ce_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_sel     = mem_sel_q;
   assign ic_rdata    = ic_rdata_q;
   assign ic_rvalid   = ic_rvalid_q;
   assign ic_beat     = ic_beat_q;
   assign ic_done     = ic_done_q;
   assign dm_rdata    = dm_rdata_q;
   assign dm_done     = dm_done_q;
   assign stallreq_ic = ic_req & ~ic_done_q;
   assign stallreq_dm = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter: per-cycle table plus hand sequences for
// contention, store capture and reset mid-burst.
module tb_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst, ic_req, dm_req, dm_we, mem_ack;
   logic [31:0] ic_addr, dm_addr, dm_wdata, mem_rdata;
   logic [3:0]  dm_sel;
   logic [31:0] ic_rdata, dm_rdata, mem_addr, mem_wdata;
   logic        ic_rvalid, ic_done, dm_done, mem_ce, mem_we, stallreq_ic, stallreq_dm;
   logic [1:0]  ic_beat;
   logic [3:0]  mem_sel;

   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(.LINE_WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid),
      .ic_beat(ic_beat), .ic_done(ic_done),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_sel(dm_sel), .dm_rdata(dm_rdata), .dm_done(dm_done),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_sel(mem_sel), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stallreq_ic(stallreq_ic), .stallreq_dm(stallreq_dm)
   );

   typedef struct packed {
      logic rst; logic ic_req; logic [31:0] ic_addr;
      logic dm_req; logic dm_we; logic [31:0] dm_addr; logic [31:0] dm_wdata; logic [3:0] dm_sel;
      logic [31:0] mem_rdata; logic mem_ack;
   } in_t;

   typedef struct packed {
      logic ce; logic we; logic [31:0] addr; logic [3:0] sel;
      logic rv; logic [1:0] beat; logic [31:0] icrd; logic icd;
      logic dmd; logic [31:0] dmrd; logic sic; logic sdm;
   } out_t;

   typedef struct { in_t i; out_t o; } vec_t;

   int unsigned n_vec = 0;
   int unsigned n_miss = 0;
   vec_t        tbl[25];

   function automatic in_t vi(logic r, logic icr, logic [31:0] ica, logic dmr, logic dwe,
                              logic [31:0] dma, logic [31:0] dwd, logic [3:0] dms,
                              logic [31:0] mrd, logic ack);
      return '{r, icr, ica, dmr, dwe, dma, dwd, dms, mrd, ack};
   endfunction

   function automatic out_t vo(logic ce, logic we, logic [31:0] a, logic [3:0] s, logic rv,
                               logic [1:0] b, logic [31:0] icrd, logic icd, logic dmd,
                               logic [31:0] dmrd, logic sic, logic sdm);
      return '{ce, we, a, s, rv, b, icrd, icd, dmd, dmrd, sic, sdm};
   endfunction

   function automatic out_t sample();
      return '{mem_ce, mem_we, mem_addr, mem_sel, ic_rvalid, ic_beat, ic_rdata, ic_done,
               dm_done, dm_rdata, stallreq_ic, stallreq_dm};
   endfunction

   function automatic string fmt(out_t o);
      return $sformatf("ce=%b we=%b addr=%h sel=%h rv=%b beat=%0d icrd=%h icd=%b dmd=%b dmrd=%h sic=%b sdm=%b",
                       o.ce, o.we, o.addr, o.sel, o.rv, o.beat, o.icrd, o.icd, o.dmd, o.dmrd, o.sic, o.sdm);
   endfunction

   task automatic drive(in_t v);
      rst = v.rst; ic_req = v.ic_req; ic_addr = v.ic_addr;
      dm_req = v.dm_req; dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
      dm_sel = v.dm_sel; mem_rdata = v.mem_rdata; mem_ack = v.mem_ack;
   endtask

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   int   exp_kind[6] = '{0, 1, 0, 1, 0, 1};
   int   ngr, gap, kind;
   logic prev_ce, finished;
   out_t got;

   initial begin
      drive(vi(H, L, 0, L, L, 0, 0, 4'h0, 0, L));
      repeat (2) @(posedge clk);

      // Lone DM load, IC refill of 0x204C, then reset + simultaneous requests.
      tbl[0]  = '{vi(H, L, 0, L, L, 0, 0, 4'h0, 0, L), vo(L, L, 0, 4'h0, L, 2'd0, 0, L, L, 0, L, L)};
      tbl[1]  = '{vi(L, L, 0, H, L, 32'h100, 0, 4'hF, 0, L), vo(L, L, 0, 4'h0, L, 2'd0, 0, L, L, 0, L, H)};
      tbl[2]  = '{vi(L, L, 0, H, L, 32'h100, 0, 4'hF, 0, L), vo(H, L, 32'h100, 4'hF, L, 2'd0, 0, L, L, 0, L, H)};
      tbl[3]  = '{vi(L, L, 0, H, L, 32'h100, 0, 4'hF, 32'hDEADBEEF, H), vo(H, L, 32'h100, 4'hF, L, 2'd0, 0, L, L, 0, L, H)};
      tbl[4]  = '{vi(L, L, 0, H, L, 32'h100, 0, 4'hF, 0, L), vo(L, L, 32'h100, 4'hF, L, 2'd0, 0, L, H, 32'hDEADBEEF, L, L)};
      tbl[5]  = '{vi(L, L, 0, L, L, 0, 0, 4'h0, 0, L), vo(L, L, 32'h100, 4'hF, L, 2'd0, 0, L, L, 32'hDEADBEEF, L, L)};
      tbl[6]  = '{vi(L, H, 32'h204C, L, L, 0, 0, 4'h0, 0, L), vo(L, L, 32'h100, 4'hF, L, 2'd0, 0, L, L, 32'hDEADBEEF, H, L)};
      tbl[7]  = '{vi(L, H, 32'h204C, L, L, 0, 0, 4'h0, 32'hA0, H), vo(H, L, 32'h2040, 4'hF, L, 2'd0, 0, L, L, 32'hDEADBEEF, H, L)};
      tbl[8]  = '{vi(L, H, 32'h204C, L, L, 0, 0, 4'h0, 32'hA1, H), vo(H, L, 32'h2044, 4'hF, H, 2'd0, 32'hA0, L, L, 32'hDEADBEEF, H, L)};
      tbl[9]  = '{vi(L, H, 32'h204C, L, L, 0, 0, 4'h0, 32'hA2, H), vo(H, L, 32'h2048, 4'hF, H, 2'd1, 32'hA1, L, L, 32'hDEADBEEF, H, L)};
      tbl[10] = '{vi(L, H, 32'h204C, L, L, 0, 0, 4'h0, 32'hA3, H), vo(H, L, 32'h204C, 4'hF, H, 2'd2, 32'hA2, L, L, 32'hDEADBEEF, H, L)};
      tbl[11] = '{vi(L, H, 32'h204C, L, L, 0, 0, 4'h0, 0, L), vo(L, L, 32'h204C, 4'hF, H, 2'd3, 32'hA3, H, L, 32'hDEADBEEF, L, L)};
      tbl[12] = '{vi(L, L, 0, L, L, 0, 0, 4'h0, 0, L), vo(L, L, 32'h204C, 4'hF, L, 2'd3, 32'hA3, L, L, 32'hDEADBEEF, L, L)};
      tbl[13] = '{vi(H, L, 0, L, L, 0, 0, 4'h0, 0, L), vo(L, L, 32'h204C, 4'hF, L, 2'd3, 32'hA3, L, L, 32'hDEADBEEF, L, L)};
      tbl[14] = '{vi(L, H, 32'h3000, H, L, 32'h400, 0, 4'hF, 0, L), vo(L, L, 0, 4'h0, L, 2'd0, 0, L, L, 0, H, H)};
      tbl[15] = '{vi(L, H, 32'h3000, H, L, 32'h400, 0, 4'hF, 32'hB0, H), vo(H, L, 32'h3000, 4'hF, L, 2'd0, 0, L, L, 0, H, H)};
      tbl[16] = '{vi(L, H, 32'h3000, H, L, 32'h400, 0, 4'hF, 32'hB1, H), vo(H, L, 32'h3004, 4'hF, H, 2'd0, 32'hB0, L, L, 0, H, H)};
      tbl[17] = '{vi(L, H, 32'h3000, H, L, 32'h400, 0, 4'hF, 32'hB2, H), vo(H, L, 32'h3008, 4'hF, H, 2'd1, 32'hB1, L, L, 0, H, H)};
      tbl[18] = '{vi(L, H, 32'h3000, H, L, 32'h400, 0, 4'hF, 32'hB3, H), vo(H, L, 32'h300C, 4'hF, H, 2'd2, 32'hB2, L, L, 0, H, H)};
      tbl[19] = '{vi(L, H, 32'h3000, H, L, 32'h400, 0, 4'hF, 0, L), vo(L, L, 32'h300C, 4'hF, H, 2'd3, 32'hB3, H, L, 0, L, H)};
      tbl[20] = '{vi(L, L, 0, H, L, 32'h400, 0, 4'hF, 0, L), vo(H, L, 32'h400, 4'hF, L, 2'd3, 32'hB3, L, L, 0, L, H)};
      tbl[21] = '{vi(L, L, 0, H, L, 32'h400, 0, 4'hF, 32'hC0FFEE00, H), vo(H, L, 32'h400, 4'hF, L, 2'd3, 32'hB3, L, L, 0, L, H)};
      tbl[22] = '{vi(L, L, 0, H, L, 32'h400, 0, 4'hF, 0, L), vo(L, L, 32'h400, 4'hF, L, 2'd3, 32'hB3, L, H, 32'hC0FFEE00, L, L)};
      tbl[23] = '{vi(L, L, 0, L, L, 0, 0, 4'h0, 32'h0BADF00D, H), vo(L, L, 32'h400, 4'hF, L, 2'd3, 32'hB3, L, L, 32'hC0FFEE00, L, L)};
      tbl[24] = '{vi(L, L, 0, L, L, 0, 0, 4'h0, 0, L), vo(L, L, 32'h400, 4'hF, L, 2'd3, 32'hB3, L, L, 32'hC0FFEE00, L, L)};

      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         drive(tbl[k].i);
         #1;
         got = sample();
         n_vec++;
         if (got !== tbl[k].o) begin
            n_miss++;
            $display("FAIL vec%0d: got %s", k, fmt(got));
            $display("FAIL vec%0d: expected %s", k, fmt(tbl[k].o));
         end
      end

      // Continuous contention: six grants must alternate, one idle cycle between.
      @(negedge clk);
      drive(vi(H, L, 0, L, L, 0, 0, 4'h0, 0, L));
      @(negedge clk);
      drive(vi(L, H, 32'h5000, H, L, 32'h9000, 0, 4'hF, 0, L));
      ngr = 0; gap = 0; prev_ce = 1'b0; finished = 1'b0;
      for (int c = 0; c < 200 && !finished; c++) begin
         @(negedge clk);
         if (mem_ce && !prev_ce) begin
            kind = (mem_addr[15:12] == 4'h5) ? 0 : 1;
            if (ngr < 6) chk($sformatf("grant%0d", ngr), kind, exp_kind[ngr]);
            if (ngr > 0) chk($sformatf("gap%0d", ngr), gap, 1);
            ngr++;
            if (ngr == 6) ic_req = 1'b0;
         end
         gap = mem_ce ? 0 : gap + 1;
         if (ngr == 6 && dm_done) begin
            dm_req   = 1'b0;
            finished = 1'b1;
         end
         mem_ack   = mem_ce;
         mem_rdata = 32'(c);
         prev_ce   = mem_ce;
      end
      chk("contention_complete", {31'd0, finished}, 1);

      // Store: request fields change mid-access, port keeps the grant-time capture.
      @(negedge clk);
      drive(vi(L, L, 0, L, L, 0, 0, 4'h0, 0, L));
      @(negedge clk);
      drive(vi(L, L, 0, H, H, 32'h600, 32'h12345678, 4'b0011, 0, L));
      @(negedge clk);
      drive(vi(L, L, 0, H, L, 32'h700, 32'hFFFFFFFF, 4'hF, 0, L));
      #1;
      chk("store_ctl1", {mem_ce, mem_we, mem_sel}, {1'b1, 1'b1, 4'b0011});
      chk("store_addr1", mem_addr, 32'h600);
      chk("store_wdata1", mem_wdata, 32'h12345678);
      @(negedge clk);
      drive(vi(L, L, 0, H, L, 32'h700, 32'hFFFFFFFF, 4'hF, 32'h77, H));
      #1;
      chk("store_ctl2", {mem_ce, mem_we, mem_sel}, {1'b1, 1'b1, 4'b0011});
      chk("store_addr2", mem_addr, 32'h600);
      chk("store_wdata2", mem_wdata, 32'h12345678);
      @(negedge clk);
      drive(vi(L, L, 0, L, L, 0, 0, 4'h0, 0, L));
      #1;
      chk("store_done", {mem_ce, dm_done}, 2'b01);

      // Reset after beat 1 of a burst, stray ack while idle, then reissue.
      @(negedge clk);
      drive(vi(L, H, 32'h8000, L, L, 0, 0, 4'h0, 0, L));
      @(negedge clk);
      drive(vi(L, H, 32'h8000, L, L, 0, 0, 4'h0, 32'hE0, H));
      #1;
      chk("burst_start", {mem_ce, mem_addr[30:0]}, {1'b1, 31'h8000});
      @(negedge clk);
      drive(vi(L, H, 32'h8000, L, L, 0, 0, 4'h0, 32'hE1, H));
      #1;
      chk("burst_beat0", {ic_rvalid, ic_beat}, 3'b100);
      @(negedge clk);
      drive(vi(H, H, 32'h8000, L, L, 0, 0, 4'h0, 0, L));
      #1;
      chk("burst_beat1", {ic_rvalid, ic_beat}, 3'b101);
      @(negedge clk);
      drive(vi(L, L, 0, L, L, 0, 0, 4'h0, 32'h55555555, H));
      #1;
      chk("rst_ctl", {mem_ce, mem_we, mem_sel, ic_rvalid, ic_done, dm_done, ic_beat}, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_icrd", ic_rdata, 0);
      chk("rst_dmrd", dm_rdata, 0);
      @(negedge clk);
      drive(vi(L, H, 32'h8000, L, L, 0, 0, 4'h0, 0, L));
      #1;
      chk("stray_ack", {mem_ce, ic_rvalid, ic_done, ic_rdata[30:0]}, 0);
      @(negedge clk);
      drive(vi(L, H, 32'h8000, L, L, 0, 0, 4'h0, 32'hF0, H));
      #1;
      chk("reissue_start", {mem_ce, mem_addr[30:0]}, {1'b1, 31'h8000});
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         mem_ack   = (b < 3);
         mem_rdata = 32'hF1 + 32'(b);
         #1;
         chk($sformatf("reissue_beat%0d", b), {ic_rvalid, ic_beat, ic_done},
             {1'b1, 2'(b), (b == 3)});
      end
      @(negedge clk);
      drive(vi(L, L, 0, L, L, 0, 0, 4'h0, 0, L));
      #1;
      chk("reissue_after", {ic_rvalid, ic_done, mem_ce}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
